// File: rtl/vga_pattern_gen_pkg.sv
// vga_pkg: shared types and constants for the VGA pattern generator.
//   pattern_e   - selectable test patterns (advance order RED->BARS->CHECK->BOX)
//   res_w/res_h - active resolution for the MODE input (0 = 800x600, 1 = 640x480)
//   COL_*       - 12-bit {R,G,B} colour constants, bar_colour() for colour bars
//   box_step    - one-frame move of the bouncing box along one axis
//   dbg_t       - internal state exported for observation
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_RED   = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_BOX   = 2'd3
  } pattern_e;

  localparam logic [11:0] W_MODE0   = 12'd800;
  localparam logic [11:0] H_MODE0   = 12'd600;
  localparam logic [11:0] W_MODE1   = 12'd640;
  localparam logic [11:0] H_MODE1   = 12'd480;
  localparam logic [11:0] COORD_MAX = 12'hFFF;

  localparam logic [11:0] COL_BLACK   = 12'h000;
  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;

  typedef struct packed {
    pattern_e    pattern;
    logic        pending;
    logic [11:0] bx;
    logic [11:0] by;
    logic        dir_x;      // 1 = moving towards larger coordinates
    logic        dir_y;
    logic        btn_level;  // debounced button level
  } dbg_t;

  function automatic logic [11:0] res_w(input logic mode);
    return mode ? W_MODE1 : W_MODE0;
  endfunction

  function automatic logic [11:0] res_h(input logic mode);
    return mode ? H_MODE1 : H_MODE0;
  endfunction

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

  // Returns {new_dir, new_pos}. Reaching a wall flips the direction and
  // moves away from it in the same step, so the box never sits still.
  function automatic logic [12:0] box_step(input logic [11:0] pos,
                                           input logic        dir,
                                           input logic [11:0] lim);
    logic [12:0] r;
    if (dir && pos >= lim)      r = {1'b0, pos - 12'd1};
    else if (!dir && pos == '0) r = {1'b1, pos + 12'd1};
    else if (dir)               r = {1'b1, pos + 12'd1};
    else                        r = {1'b0, pos - 12'd1};
    return r;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video stream between the timing generators and the pattern generator.
// master: timing side (drives sync/active, observes pixels).
// slave:  pattern generator (consumes sync/active, drives pixels).
// Flow semantics: DISP_ACTIVE is the per-cycle valid qualifier for a pixel;
// there is no ready - the stream cannot be stalled, one pixel per clock.
interface vga_pattern_gen_if;
  logic        HSync;
  logic        VSync;
  logic        DISP_ACTIVE;
  logic [3:0]  Rv;
  logic [3:0]  Gv;
  logic [3:0]  Bv;
  logic [11:0] XPOS;
  logic [11:0] YPOS;
  logic        HSync_d;
  logic        VSync_d;
  logic        DISP_ACTIVE_d;

  modport master (
    output HSync, VSync, DISP_ACTIVE,
    input  Rv, Gv, Bv, XPOS, YPOS, HSync_d, VSync_d, DISP_ACTIVE_d
  );

  modport slave (
    input  HSync, VSync, DISP_ACTIVE,
    output Rv, Gv, Bv, XPOS, YPOS, HSync_d, VSync_d, DISP_ACTIVE_d
  );
endinterface

// File: rtl/vga_pattern_gen_btn_debounce.sv
// btn_debounce: 2-flop synchroniser followed by a stability counter.
//   clk, rst  - clock, synchronous active-high reset
//   btn_raw   - asynchronous button input
//   level     - debounced level (0 after reset)
//   rise      - one-cycle pulse when level goes 0 -> 1
// A new level is accepted after DEB_CYCLES consecutive synchronised samples
// that differ from the current level; a sample equal to it reloads the count.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      level_d = sync_q[1];
      rise_d  = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: pixel stage producing registered RGB444 test patterns.
//   CLK, RST  - pixel clock, synchronous active-high reset
//   MODE      - 0 = 800x600, 1 = 640x480; a change restarts coordinates/box
//   PAT_BTN   - raw button, each debounced press advances the pattern at the
//               next VSync rising edge (at most one step per frame)
//   vif       - slave side of the video stream (sync/active in, pixels out)
//   dbg       - pattern, pending press, box state, debounced button level
// All outputs lag the sync/active inputs by one clock.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int BOX_SIZE   = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MODE,
  input  logic                    PAT_BTN,
  vga_pattern_gen_if.slave        vif,
  output dbg_t                    dbg
);
  localparam logic [11:0] BOX = 12'(BOX_SIZE);

  logic        btn_level, btn_rise;
  logic        mode_q;
  logic [11:0] x_q, x_d, y_q, y_d, bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [11:0] bx_q, bx_d, by_q, by_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  pattern_e    pattern_q, pattern_d;
  logic        pending_q, pending_d;
  logic [11:0] rgb_q, rgb_d, xpos_q, xpos_d, ypos_q;
  logic        hs_q, vs_q, de_q;

  logic [11:0] w, h, bar_w, colour;
  logic        mode_chg, da_fall, frame_tick, in_box;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk    (CLK),
    .rst    (RST),
    .btn_raw(PAT_BTN),
    .level  (btn_level),
    .rise   (btn_rise)
  );

  always_comb begin
    w          = res_w(MODE);
    h          = res_h(MODE);
    bar_w      = w >> 3;
    mode_chg   = MODE ^ mode_q;
    da_fall    = de_q & ~vif.DISP_ACTIVE;
    frame_tick = vif.VSync & ~vs_q;

    // X and the bar counters run together so the bar index never needs a divide.
    x_d       = x_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (mode_chg || da_fall) begin
      x_d       = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (vif.DISP_ACTIVE) begin
      if (x_q != COORD_MAX) x_d = x_q + 12'd1;
      if (bar_cnt_q >= bar_w - 12'd1) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 12'd1;
      end
    end

    y_d = y_q;
    if (mode_chg || frame_tick)        y_d = '0;
    else if (da_fall && y_q != COORD_MAX) y_d = y_q + 12'd1;

    bx_d    = bx_q;
    by_d    = by_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (mode_chg) begin
      bx_d    = '0;
      by_d    = '0;
      dir_x_d = 1'b1;
      dir_y_d = 1'b1;
    end else if (frame_tick) begin
      {dir_x_d, bx_d} = box_step(bx_q, dir_x_q, w - BOX);
      {dir_y_d, by_d} = box_step(by_q, dir_y_q, h - BOX);
    end

    // A press landing on the tick cycle itself is kept for the next frame.
    pending_d = btn_rise | (pending_q & ~frame_tick);
    pattern_d = pattern_q;
    if (frame_tick && pending_q) pattern_d = pattern_e'(pattern_q + 2'd1);

    in_box = ({1'b0, x_q} >= {1'b0, bx_q}) && ({1'b0, x_q} < {1'b0, bx_q} + {1'b0, BOX}) &&
             ({1'b0, y_q} >= {1'b0, by_q}) && ({1'b0, y_q} < {1'b0, by_q} + {1'b0, BOX});

    colour = COL_BLACK;
    case (pattern_q)
      PAT_RED:   colour = COL_RED;
      PAT_BARS:  colour = bar_colour(bar_idx_q);
      PAT_CHECK: colour = (x_q[5] ^ y_q[5]) ? COL_WHITE : COL_BLACK;
      PAT_BOX:   colour = in_box ? COL_WHITE : COL_BLUE;
      default:   colour = COL_BLACK;
    endcase

    rgb_d  = vif.DISP_ACTIVE ? colour : COL_BLACK;
    xpos_d = vif.DISP_ACTIVE ? x_q : '0;
  end

  always_ff @(posedge CLK) begin
    mode_q <= MODE;  // tracks MODE even in reset so release never looks like a change
    if (RST) begin
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      pattern_q <= PAT_RED;
      pending_q <= 1'b0;
      rgb_q     <= '0;
      xpos_q    <= '0;
      ypos_q    <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      pattern_q <= pattern_d;
      pending_q <= pending_d;
      rgb_q     <= rgb_d;
      xpos_q    <= xpos_d;
      ypos_q    <= y_q;
      hs_q      <= vif.HSync;
      vs_q      <= vif.VSync;
      de_q      <= vif.DISP_ACTIVE;
    end
  end

  assign vif.Rv            = rgb_q[11:8];
  assign vif.Gv            = rgb_q[7:4];
  assign vif.Bv            = rgb_q[3:0];
  assign vif.XPOS          = xpos_q;
  assign vif.YPOS          = ypos_q;
  assign vif.HSync_d       = hs_q;
  assign vif.VSync_d       = vs_q;
  assign vif.DISP_ACTIVE_d = de_q;

  always_comb begin
    dbg.pattern   = pattern_q;
    dbg.pending   = pending_q;
    dbg.bx        = bx_q;
    dbg.by        = by_q;
    dbg.dir_x     = dir_x_q;
    dbg.dir_y     = dir_y_q;
    dbg.btn_level = btn_level;
  end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with a short debounce (4 cycles).
module tb_vga_pattern_gen;
  import vga_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b1;
  logic pat_btn = 1'b0;
  dbg_t dbg;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_pattern_gen_if vif();

  vga_pattern_gen #(.DEB_CYCLES(4), .BOX_SIZE(32)) dut (
    .CLK    (clk),
    .RST    (rst),
    .MODE   (mode),
    .PAT_BTN(pat_btn),
    .vif    (vif),
    .dbg    (dbg)
  );

  logic [11:0] rgb;
  assign rgb = {vif.Rv, vif.Gv, vif.Bv};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    vif.VSync = 1'b1;
    tick();
    vif.VSync = 1'b0;
    tick();
  endtask

  task automatic press(input int n);
    pat_btn = 1'b1;
    repeat (n) tick();
    pat_btn = 1'b0;
    repeat (10) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    dbg_t exp_dbg;
    rst = 1'b1;
    vif.DISP_ACTIVE = 1'b1;
    vif.HSync = 1'b1;
    vif.VSync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rgb, vif.XPOS, vif.YPOS, vif.HSync_d, vif.VSync_d, vif.DISP_ACTIVE_d} !== 39'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: rgb=%h x=%0d y=%0d hs=%b vs=%b de=%b, required all 0",
                 i, rgb, vif.XPOS, vif.YPOS, vif.HSync_d, vif.VSync_d, vif.DISP_ACTIVE_d);
      end
    end
    rst = 1'b0;
    vif.DISP_ACTIVE = 1'b0;
    vif.HSync = 1'b0;
    vif.VSync = 1'b0;
    tick();
    exp_dbg = '0;
    exp_dbg.pattern = PAT_RED;
    exp_dbg.dir_x = 1'b1;
    exp_dbg.dir_y = 1'b1;
    checks++;
    if (dbg !== exp_dbg) begin
      errors++;
      $display("FAIL reset_state: dbg=%h required %h", dbg, exp_dbg);
    end
  endtask

  task automatic test_red_frame();
    vif.DISP_ACTIVE = 1'b1;
    for (int i = 0; i < 640; i++) begin
      tick();
      checks++;
      if (vif.XPOS !== 12'(i) || rgb !== 12'hF00 || vif.DISP_ACTIVE_d !== 1'b1) begin
        errors++;
        $display("FAIL red_pixel: x=%0d rgb=%h de=%b, required x=%0d rgb=f00 de=1",
                 vif.XPOS, rgb, vif.DISP_ACTIVE_d, i);
      end
    end
    vif.DISP_ACTIVE = 1'b0;
    tick();
    checks++;
    if (vif.XPOS !== 12'd0 || rgb !== 12'h000 || vif.DISP_ACTIVE_d !== 1'b0) begin
      errors++;
      $display("FAIL red_line_end: x=%0d rgb=%h de=%b, required x=0 rgb=000 de=0",
               vif.XPOS, rgb, vif.DISP_ACTIVE_d);
    end
    tick();
    checks++;
    if (vif.YPOS !== 12'd1) begin
      errors++;
      $display("FAIL red_y_inc: y=%0d required 1", vif.YPOS);
    end
  endtask

  task automatic test_button_pattern();
    mode = 1'b0;
    tick();
    frame_pulse();
    press(10);
    checks++;
    if (dbg.pattern !== PAT_RED || dbg.pending !== 1'b1) begin
      errors++;
      $display("FAIL btn_pending: pattern=%0d pending=%b, required 0/1", dbg.pattern, dbg.pending);
    end
    vif.DISP_ACTIVE = 1'b1;
    tick();
    checks++;
    if (rgb !== 12'hF00) begin
      errors++;
      $display("FAIL btn_still_red: rgb=%h required f00", rgb);
    end
    vif.DISP_ACTIVE = 1'b0;
    tick();
    vif.VSync = 1'b1;
    tick();
    checks++;
    if (dbg.pattern !== PAT_BARS || dbg.pending !== 1'b0) begin
      errors++;
      $display("FAIL btn_advance: pattern=%0d pending=%b, required 1/0", dbg.pattern, dbg.pending);
    end
    vif.VSync = 1'b0;
    tick();
    vif.DISP_ACTIVE = 1'b1;
    for (int i = 0; i < 800; i++) begin
      logic [11:0] exp_c;
      tick();
      exp_c = 12'hxxx;
      if (i == 0)   exp_c = 12'hFFF;
      if (i == 99)  exp_c = 12'hFFF;
      if (i == 100) exp_c = 12'hFF0;
      if (i == 699) exp_c = 12'h00F;
      if (i == 700) exp_c = 12'h000;
      if (i == 799) exp_c = 12'h000;
      if (i == 0 || i == 99 || i == 100 || i == 699 || i == 700 || i == 799) begin
        checks++;
        if (vif.XPOS !== 12'(i) || rgb !== exp_c) begin
          errors++;
          $display("FAIL bars_pixel: x=%0d rgb=%h, required x=%0d rgb=%h", vif.XPOS, rgb, i, exp_c);
        end
      end
    end
    vif.DISP_ACTIVE = 1'b0;
    tick();
  endtask

  task automatic test_two_presses();
    press(10);
    press(10);
    checks++;
    if (dbg.pending !== 1'b1) begin
      errors++;
      $display("FAIL two_press_pending: pending=%b required 1", dbg.pending);
    end
    frame_pulse();
    checks++;
    if (dbg.pattern !== PAT_CHECK) begin
      errors++;
      $display("FAIL two_press_advance: pattern=%0d required 2", dbg.pattern);
    end
    vif.DISP_ACTIVE = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 31 || i == 32) begin
        checks++;
        if (rgb !== ((i == 32) ? 12'hFFF : 12'h000)) begin
          errors++;
          $display("FAIL check_pixel: x=%0d rgb=%h required %h", i, rgb,
                   (i == 32) ? 12'hFFF : 12'h000);
        end
      end
    end
    vif.DISP_ACTIVE = 1'b0;
    tick();
    press(3);
    checks++;
    if (dbg.pending !== 1'b0 || dbg.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL glitch_pending: pending=%b level=%b required 0/0", dbg.pending, dbg.btn_level);
    end
    frame_pulse();
    checks++;
    if (dbg.pattern !== PAT_CHECK) begin
      errors++;
      $display("FAIL glitch_no_advance: pattern=%0d required 2", dbg.pattern);
    end
  endtask

  task automatic test_box_bounce();
    press(10);
    frame_pulse();
    mode = 1'b1;
    tick();
    checks++;
    if (dbg.pattern !== PAT_BOX || dbg.bx !== 12'd0 || dbg.by !== 12'd0) begin
      errors++;
      $display("FAIL box_start: pattern=%0d bx=%0d by=%0d required 3/0/0", dbg.pattern, dbg.bx, dbg.by);
    end
    for (int f = 1; f <= 610; f++) begin
      frame_pulse();
      if (f == 448) begin
        checks++;
        if (dbg.by !== 12'd448) begin
          errors++;
          $display("FAIL box_by_448: by=%0d required 448", dbg.by);
        end
      end
      if (f == 449) begin
        checks++;
        if (dbg.by !== 12'd447 || dbg.dir_y !== 1'b0) begin
          errors++;
          $display("FAIL box_by_rev: by=%0d dir=%b required 447/0", dbg.by, dbg.dir_y);
        end
      end
      if (f == 608) begin
        checks++;
        if (dbg.bx !== 12'd608) begin
          errors++;
          $display("FAIL box_bx_608: bx=%0d required 608", dbg.bx);
        end
      end
      if (f == 609) begin
        checks++;
        if (dbg.bx !== 12'd607 || dbg.dir_x !== 1'b0) begin
          errors++;
          $display("FAIL box_bx_rev: bx=%0d dir=%b required 607/0", dbg.bx, dbg.dir_x);
        end
      end
    end
    checks++;
    if (dbg.bx !== 12'd606 || dbg.by !== 12'd286) begin
      errors++;
      $display("FAIL box_final: bx=%0d by=%0d required 606/286", dbg.bx, dbg.by);
    end
    for (int l = 0; l < 286; l++) begin
      vif.DISP_ACTIVE = 1'b1;
      tick();
      vif.DISP_ACTIVE = 1'b0;
      tick();
    end
    vif.DISP_ACTIVE = 1'b1;
    for (int i = 0; i < 640; i++) begin
      tick();
      if (i == 605 || i == 606 || i == 637 || i == 638) begin
        checks++;
        if (vif.XPOS !== 12'(i) || vif.YPOS !== 12'd286 ||
            rgb !== ((i == 606 || i == 637) ? 12'hFFF : 12'h00F)) begin
          errors++;
          $display("FAIL box_pixel: x=%0d y=%0d rgb=%h required x=%0d y=286 rgb=%h", vif.XPOS,
                   vif.YPOS, rgb, i, (i == 606 || i == 637) ? 12'hFFF : 12'h00F);
        end
      end
    end
    vif.DISP_ACTIVE = 1'b0;
    tick();
  endtask

  task automatic test_mode_change();
    mode = 1'b0;
    tick();
    press(10);
    frame_pulse();
    press(10);
    frame_pulse();
    checks++;
    if (dbg.pattern !== PAT_BARS || dbg.bx !== 12'd2) begin
      errors++;
      $display("FAIL mode_setup: pattern=%0d bx=%0d required 1/2", dbg.pattern, dbg.bx);
    end
    vif.DISP_ACTIVE = 1'b1;
    repeat (50) tick();
    mode = 1'b1;
    tick();
    checks++;
    if (dbg.pattern !== PAT_BARS || dbg.bx !== 12'd0 || dbg.by !== 12'd0 ||
        dbg.dir_x !== 1'b1 || dbg.dir_y !== 1'b1) begin
      errors++;
      $display("FAIL mode_box_reset: pattern=%0d bx=%0d by=%0d dx=%b dy=%b required 1/0/0/1/1",
               dbg.pattern, dbg.bx, dbg.by, dbg.dir_x, dbg.dir_y);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (vif.XPOS !== 12'(i) || vif.YPOS !== 12'd0) begin
        errors++;
        $display("FAIL mode_x_restart: x=%0d y=%0d required %0d/0", vif.XPOS, vif.YPOS, i);
      end
      if (i == 79 || i == 80) begin
        checks++;
        if (rgb !== ((i == 80) ? 12'hFF0 : 12'hFFF)) begin
          errors++;
          $display("FAIL mode_bar_edge: x=%0d rgb=%h required %h", i, rgb,
                   (i == 80) ? 12'hFF0 : 12'hFFF);
        end
      end
    end
    vif.DISP_ACTIVE = 1'b0;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vif.HSync = 1'b0;
    vif.VSync = 1'b0;
    vif.DISP_ACTIVE = 1'b0;
    test_reset();
    test_red_frame();
    test_button_pattern();
    test_two_presses();
    test_box_bounce();
    test_mode_change();
    frame_pulse();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Downstream pixel stage of the VGA pipeline. Consumes the sync and display-active signals from the horizontal/vertical timing generators and produces registered 4-bit-per-channel RGB plus pixel coordinates. Provides four selectable test patterns, chosen with a debounced push-button. Pattern changes are frame-synchronous, so there is no tearing.

## Interface
- DEB_CYCLES, 500000: button must be stable for this many CLK cycles before it is accepted.
- BOX_SIZE, 32: side length in pixels of the bouncing square.
- CLK  in  1  pixel clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- MODE  in  1  resolution select: 0 = 800x600, 1 = 640x480. Same encoding as the timing generators.
- HSync  in  1  horizontal sync, active-high pulse.
- VSync  in  1  vertical sync, active-high pulse.
- DISP_ACTIVE  in  1  high during visible pixels.
- PAT_BTN  in  1  raw asynchronous pattern-advance button.
- Rv, Gv, Bv  out  4 each  pixel colour, registered.
- XPOS, YPOS  out  12 each  coordinates of the pixel currently on Rv/Gv/Bv.
- HSync_d, VSync_d, DISP_ACTIVE_d  out  1 each  inputs delayed one cycle, aligned with the RGB outputs.

## Operation
- **Resolution:** W/H = 800/600 when MODE=0, 640/480 when MODE=1. MODE is sampled every cycle.
- **X counter:**
  - increments each cycle DISP_ACTIVE=1;
  - clears on the cycle DISP_ACTIVE falls.
- **Y counter:**
  - increments when DISP_ACTIVE falls;
  - clears on the VSync rising edge.
  - VSync clear wins over increment when both occur in the same cycle.
- **Frame tick:** single-cycle pulse on the VSync rising edge (previous 0, current 1).
- **Button path:**
  - 2-flop synchroniser, then debouncer.
  - Debounced rising edge sets `pending_next`.
  - On the frame tick: pattern = pattern+1 mod 4, and `pending_next` clears.
  - Multiple presses within one frame advance by exactly one.
- **Pattern encoding:**
  - PAT_RED = 0: F,0,0.
  - PAT_BARS = 1: eight vertical bars of width W/8 (100 or 80). Order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000. Bar index comes from a bar-width counter plus a 3-bit index, not a divider. Both clear with X.
  - PAT_CHECK = 2: X[5]^Y[5] ? FFF : 000.
  - PAT_BOX = 3:
    - FFF inside [bx, bx+BOX_SIZE) × [by, by+BOX_SIZE), 00F elsewhere.
    - Box position updates on each frame tick, one pixel per axis.
    - Bounce: if moving + and bx == W-BOX_SIZE, direction becomes − and bx decrements. If moving − and bx == 0, direction becomes + and bx increments. Y axis behaves the same using H.
    - Box state updates in every pattern, not only when PAT_BOX is shown.
- **Blanking:** RGB = 000 whenever the delayed DISP_ACTIVE is 0. RGB is driven, never Z.
- **MODE change:**
  - Detected as MODE differing from its registered copy.
  - Resets box to (0,0) with direction +,+.
  - Clears X/Y counters and the bar counter.
  - Pattern and pending press are untouched.

## Timing
- **Latency:** one cycle from DISP_ACTIVE/HSync/VSync inputs to RGB/XPOS/YPOS and the *_d outputs.
- **Reset values** (RST high at a posedge):
  - all outputs 0;
  - X, Y, bar counter 0;
  - pattern = PAT_RED; `pending_next` = 0;
  - box (0,0) with direction +,+;
  - debouncer cleared, stable level 0.
- **Reset mid-frame:** outputs are 0 the cycle after the RST edge. Coordinates resynchronise on the next DISP_ACTIVE fall / VSync rise.
- **Debouncer:** accepts a new level after DEB_CYCLES consecutive equal samples. Any differing sample reloads the counter.
- **Width:** X/Y counters saturate at 4095. Nominal modes never reach that limit.

## Structure
- **Package `vga_pkg`:**
  - pattern enum;
  - resolution constants per MODE (800/600, 640/480);
  - bar colour table;
  - colour constants.
- **Sub-module `btn_debounce`:** synchroniser + counter + stable level. Outputs level and rise pulse. Parameter DEB_CYCLES.
- Everything else stays in the top module: counters, pattern register, box state, output register.

## Test plan
- **Reset:** RST=1 for 3 cycles during active video → every output 0. Pattern reads PAT_RED after release.
- **Red frame:** MODE=1, drive 640 active cycles → RGB = F,0,0 with XPOS 0..639. Cycle after the last active pixel → XPOS=0 and RGB=000.
- **Button + pattern:** DEB_CYCLES=4. Press 10 cycles mid-frame → pattern unchanged until the VSync rise, then PAT_BARS. In MODE=0, X=99 is white (FFF), X=100 is yellow (FF0), X=799 is black.
- **Two presses in one frame** → exactly one advance. A 3-cycle glitch press with DEB_CYCLES=4 → no advance.
- **Box bounce:** MODE=1, PAT_BOX, run 610 frames → bx reaches 608 at frame 608, then 607 at frame 609. by reverses at 448. Pixel (bx,by) is FFF and (bx+32,by) is 00F.
- **MODE change:** toggle MODE 0→1 mid-frame → box at (0,0) and X cleared next cycle, pattern preserved. In PAT_BARS the first bar boundary moves to X=80.
